// File: rtl/dd_video_pkg.sv
// Shared video timing and sprite line-buffer constants.
package dd_video_pkg;

    localparam int unsigned HPOS_W    = 9;
    localparam int unsigned LINE_W    = 288;
    localparam int unsigned PIX_W     = 4;
    localparam int unsigned VIS_LINES = 224;

    localparam logic [HPOS_W-1:0] HPOS_SWAP = 9'd511;

endpackage

// File: rtl/dd_line_dpram.sv
// One sprite line bank: port A is the build-side read + write, port B the scan-out read/clear.
module dd_line_dpram #(
    parameter  int unsigned LINE_W = 288,
    parameter  int unsigned PIX_W  = 4,
    localparam int unsigned ADDR_W = $clog2(LINE_W)
) (
    input  logic              clk,
    input  logic              a_ren,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [PIX_W-1:0]  a_rdata,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [PIX_W-1:0]  a_wdata,
    input  logic              b_en,
    input  logic              b_show,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [PIX_W-1:0]  b_rdata
);

    logic [PIX_W-1:0] mem [LINE_W];

    // Port B returns zero unless shown, so the two banks' outputs can simply be ORed.
    always_ff @(posedge clk) begin
        if (a_ren) begin
            a_rdata <= mem[a_raddr];
        end
        b_rdata <= (b_en && b_show) ? mem[b_addr] : '0;
        if (b_en) begin
            mem[b_addr] <= '0;
        end
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
    end

endmodule

// File: rtl/dd_sprlinebuf.sv
// Double-banked sprite line buffer: first-write-wins build bank, clear-on-read display bank.
module dd_sprlinebuf #(
    parameter int unsigned LINE_W = dd_video_pkg::LINE_W,
    parameter int unsigned PIX_W  = dd_video_pkg::PIX_W
) (
    input  logic             PCLK,
    input  logic             RST,
    input  logic [8:0]       HPOS,
    input  logic [8:0]       VPOS,
    input  logic             WR_EN,
    input  logic [8:0]       WR_X,
    input  logic [PIX_W-1:0] WR_PIX,
    output logic             WR_READY,
    output logic [PIX_W-1:0] OPIX,
    output logic             OVALID
);

    localparam int unsigned HPOS_W = dd_video_pkg::HPOS_W;
    localparam int unsigned ADDR_W = $clog2(LINE_W);
    localparam logic [HPOS_W-1:0] LINE_END = HPOS_W'(LINE_W);
    localparam logic [HPOS_W-1:0] VIS_END  = HPOS_W'(dd_video_pkg::VIS_LINES);

    logic             swap_c;
    logic             hvis_c;
    logic             wr_take_c;
    logic             bsel;
    logic [1:0]       swap_cnt;
    logic             primed;

    logic             s2_vld;
    logic             s2_bank;
    logic [ADDR_W-1:0] s2_x;
    logic [PIX_W-1:0] s2_pix;

    logic             fwd_vld;
    logic             fwd_bank;
    logic [ADDR_W-1:0] fwd_x;
    logic [PIX_W-1:0] fwd_val;

    logic [PIX_W-1:0] old_c;
    logic [PIX_W-1:0] merged_c;
    logic             wr_c;

    logic [PIX_W-1:0] a_rdata [2];
    logic [PIX_W-1:0] b_rdata [2];

    assign swap_c    = (HPOS == dd_video_pkg::HPOS_SWAP);
    assign hvis_c    = (HPOS < LINE_END);
    assign WR_READY  = !RST && !swap_c;
    assign wr_take_c = WR_EN && WR_READY && (WR_PIX != '0) && (WR_X < LINE_END);

    // Stage 2: the previous stage-2 result overrides a RAM read that raced its write.
    always_comb begin
        old_c = s2_bank ? a_rdata[1] : a_rdata[0];
        if (fwd_vld && (fwd_bank == s2_bank) && (fwd_x == s2_x)) begin
            old_c = fwd_val;
        end
        merged_c = (old_c != '0) ? old_c : s2_pix;
        wr_c     = s2_vld && !RST && (old_c == '0);
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            bsel     <= 1'b0;
            swap_cnt <= 2'd0;
            primed   <= 1'b0;
            s2_vld   <= 1'b0;
            fwd_vld  <= 1'b0;
            OVALID   <= 1'b0;
        end else begin
            if (swap_c) begin
                bsel <= ~bsel;
                if (swap_cnt != 2'd2) begin
                    swap_cnt <= swap_cnt + 2'd1;
                end
                if (swap_cnt == 2'd1) begin
                    primed <= 1'b1;
                end
            end
            s2_vld  <= wr_take_c;
            fwd_vld <= s2_vld;
            OVALID  <= hvis_c && (VPOS < VIS_END) && primed;
        end
    end

    // Pipeline payload; qualified by the valid bits above.
    always_ff @(posedge PCLK) begin
        if (wr_take_c) begin
            s2_x    <= ADDR_W'(WR_X);
            s2_pix  <= WR_PIX;
            s2_bank <= bsel;
        end
        fwd_bank <= s2_bank;
        fwd_x    <= s2_x;
        fwd_val  <= merged_c;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        dd_line_dpram #(
            .LINE_W (LINE_W),
            .PIX_W  (PIX_W)
        ) u_ram (
            .clk     (PCLK),
            .a_ren   (wr_take_c && (bsel == 1'(g))),
            .a_raddr (ADDR_W'(WR_X)),
            .a_rdata (a_rdata[g]),
            .a_we    (wr_c && (s2_bank == 1'(g))),
            .a_waddr (s2_x),
            .a_wdata (s2_pix),
            .b_en    (!RST && hvis_c && (bsel != 1'(g))),
            .b_show  (primed),
            .b_addr  (ADDR_W'(HPOS)),
            .b_rdata (b_rdata[g])
        );
    end

    assign OPIX = b_rdata[0] | b_rdata[1];

endmodule

// File: tb/tb_dd_sprlinebuf.sv
// Scoreboard bench for dd_sprlinebuf against a line-level behavioural model.
module tb_dd_sprlinebuf;

    localparam int LW   = 288;
    localparam int PW   = 4;
    localparam int VTOT = 228;

    logic          PCLK = 1'b0;
    logic          RST;
    logic [8:0]    HPOS;
    logic [8:0]    VPOS;
    logic          WR_EN;
    logic [8:0]    WR_X;
    logic [PW-1:0] WR_PIX;
    logic          WR_READY;
    logic [PW-1:0] OPIX;
    logic          OVALID;

    dd_sprlinebuf dut (
        .PCLK     (PCLK),
        .RST      (RST),
        .HPOS     (HPOS),
        .VPOS     (VPOS),
        .WR_EN    (WR_EN),
        .WR_X     (WR_X),
        .WR_PIX   (WR_PIX),
        .WR_READY (WR_READY),
        .OPIX     (OPIX),
        .OVALID   (OVALID)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { bit rdy; bit ov; int pix; } exp_t;
    typedef struct { int h; int x; int pix; } wr_t;

    exp_t sb [$];
    wr_t  wq [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: physical banks (-1 = unknown contents), role select, priming.
    int bank [2][LW];
    bit m_bsel, m_primed;
    int m_swaps;
    bit pend_v, pend_b;
    int pend_x, pend_p;
    bit out_ov;
    int out_pix;
    int h, v;

    int obs [LW];
    int prev_h;
    int ov_hits, pix_hits;
    bit rnd_on;
    int rst_h;
    int last_x;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit we, input int x, input int pix);
        exp_t e;
        bit   rdy;
        int   db;
        rdy   = !rst && (h != 511);
        e.rdy = rdy;
        e.ov  = out_ov;
        e.pix = out_pix;
        sb.push_back(e);
        // A write accepted last cycle lands now unless reset kills it.
        if (pend_v && !rst && bank[pend_b][pend_x] == 0) bank[pend_b][pend_x] = pend_p;
        pend_v = 1'b0;
        db = m_bsel ? 0 : 1;
        if (rst) begin
            out_ov  = 1'b0;
            out_pix = 0;
            m_bsel  = 1'b0;
            m_swaps = 0;
            m_primed = 1'b0;
        end else begin
            out_ov  = (h < LW) && (v < 224) && m_primed;
            out_pix = 0;
            if (h < LW) begin
                if (m_primed) out_pix = bank[db][h];
                bank[db][h] = 0;
            end
            if (rdy && we && pix != 0 && x < LW) begin
                pend_v = 1'b1;
                pend_b = m_bsel;
                pend_x = x;
                pend_p = pix;
            end
            if (h == 511) begin
                m_bsel = !m_bsel;
                m_swaps++;
                if (m_swaps == 2) m_primed = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit we, input int x, input int pix);
        @(posedge PCLK);
        #1;
        HPOS   = 9'(h);
        VPOS   = 9'(v);
        RST    = rst;
        WR_EN  = we;
        WR_X   = 9'(x);
        WR_PIX = PW'(pix);
        step(rst, we, x, pix);
        if (h == 342) h = 471;
        else if (h == 511) begin
            h = 0;
            v = (v + 1) % VTOT;
        end else h++;
    endtask

    task automatic run_line();
        do begin
            bit we;
            int x, p, hi;
            we = 1'b0; x = 0; p = 0; hi = h;
            for (int i = 0; i < wq.size(); i++) begin
                if (wq[i].h == h) begin
                    we = 1'b1; x = wq[i].x; p = wq[i].pix;
                    wq.delete(i);
                    break;
                end
            end
            if (!we && rnd_on && $urandom_range(2) == 0) begin
                we = 1'b1;
                x  = ($urandom_range(3) == 0) ? last_x : int'($urandom_range(299));
                p  = int'($urandom_range(15));
                last_x = x;
            end
            cycle(hi == rst_h, we, x, p);
            if (rst_h >= 0 && hi == rst_h + 1) ov_hits = 0;
        end while (h != 0);
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        prev_h = 511;
        forever begin
            @(negedge PCLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("wr_ready h=%0d", HPOS), int'(WR_READY), int'(e.rdy));
                check($sformatf("ovalid h=%0d", prev_h), int'(OVALID), int'(e.ov));
                if (e.pix >= 0) check($sformatf("opix h=%0d", prev_h), int'(OPIX), e.pix);
                if (OVALID === 1'b1) ov_hits++;
                if (OPIX != '0) pix_hits++;
                if (prev_h < LW) obs[prev_h] = int'(OPIX);
                prev_h = int'(HPOS);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        RST = 1'b1; HPOS = '0; VPOS = '0; WR_EN = 1'b0; WR_X = '0; WR_PIX = '0;
        foreach (bank[b, i]) bank[b][i] = -1;
        m_bsel = 1'b0; m_primed = 1'b0; m_swaps = 0; pend_v = 1'b0;
        out_ov = 1'b0; out_pix = 0;
        rnd_on = 1'b0; rst_h = -1; last_x = 0;
        h = 500; v = 0;
        while (h != 0) cycle(1'b1, 1'b0, 0, 0);
        v = 212;
        ov_hits = 0; pix_hits = 0;

        // Two idle lines after reset: never valid, never a pixel.
        run_line();
        run_line();
        check("idle_ovalid_hits", ov_hits, 0);
        check("idle_opix_hits", pix_hits, 0);

        wq.push_back('{50, 10, 5});
        run_line();
        run_line();
        check("x10_shown", obs[10], 5);
        check("x9_empty", obs[9], 0);
        check("x11_empty", obs[11], 0);

        wq.push_back('{60, 20, 3});
        wq.push_back('{61, 20, 7});
        run_line();
        check("x10_cleared", obs[10], 0);

        wq.push_back('{70, 30, 0});
        wq.push_back('{71, 300, 9});
        run_line();
        check("x20_first_wins", obs[20], 3);

        wq.push_back('{510, 40, 6});
        wq.push_back('{511, 40, 6});
        run_line();
        check("x30_zero_write", obs[30], 0);
        nz = 0;
        foreach (obs[i]) if (obs[i] != 0) nz++;
        check("ignored_writes_line_empty", nz, 0);

        wq.push_back('{0, 40, 6});
        run_line();
        check("x40_from_510", obs[40], 6);
        run_line();
        check("x40_from_0", obs[40], 6);
        run_line();
        check("x40_cleared", obs[40], 0);

        rnd_on = 1'b1;
        repeat (8) run_line();
        rnd_on = 1'b0;

        // Mid-line reset with the X=50 write in stage 2 while bank 1 is building.
        if (m_bsel != 1'b1) run_line();
        wq.push_back('{99, 50, 11});
        rst_h = 100;
        run_line();
        rst_h = -1;
        run_line();
        check("post_reset_ovalid_hits", ov_hits, 0);
        ov_hits = 0;
        run_line();
        check("lost_write_x50", obs[50], 0);
        check("ovalid_returns", int'(ov_hits > 0), 1);

        @(negedge PCLK);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
